memory_gap_stats: RTL and testbench

MEMORY_GAP_STATS -- requirements
Module: memory_gap_stats

---
 rtl/memory_gap_stats.sv | 191 +++++++++++++++++++
 tb/tb_memory_gap_stats.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_gap_stats.sv
// memory_gap_stats: histogram and running statistics (count, min, max, sum)
// of memory-gap samples, with a one-cycle registered bin read port.
// Statistics freeze in SATURATED once any counter or the sum hits all-ones.
module memory_gap_stats #(
   parameter int NUM_BINS  = 8,
   parameter int BIN_SHIFT = 2,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [31:0]          memory_gap,
   input  logic                        memory_gap_valid,
   input  logic                        enable,
   input  logic                        clear,
   input  logic                        rd_req,
   input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
   output logic                        rd_valid,
   output logic [CNT_W-1:0]            rd_data,
   output logic [CNT_W-1:0]            sample_count,
   output logic [31:0]                 gap_min,
   output logic [31:0]                 gap_max,
   output logic [39:0]                 gap_sum,
   output logic [7:0]                  discard_count,
   output logic [1:0]                  state
);

   localparam int                BIN_W    = $clog2(NUM_BINS);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [39:0]       SUM_MAX  = '1;
   localparam logic [31:0]       MIN_INIT = 32'h7FFF_FFFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      SATURATED = 2'd2
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    bin_reg [NUM_BINS];
   logic [NUM_BINS-1:0] bin_full_next;
   logic [CNT_W-1:0]    sample_count_reg;
   logic [39:0]         gap_sum_reg;
   logic [39:0]         gap_sum_next;
   logic [40:0]         gap_sum_ext;
   logic [31:0]         gap_min_reg;
   logic [31:0]         gap_max_reg;
   logic [7:0]          discard_count_reg;
   logic                rd_valid_reg;
   logic [CNT_W-1:0]    rd_data_reg;

   logic [31:0]         gap_u;
   logic [31:0]         gap_shifted;
   logic [BIN_W-1:0]    bin_idx;
   logic                accept;
   logic                discard;
   logic                cnt_full_next;
   logic                sum_full_next;
   logic                sat_next;

   // A negative gap has bit 31 set; clear always wins over a coincident sample.
   assign gap_u       = memory_gap;
   assign accept      = (state_reg == COLLECT) && enable && memory_gap_valid &&
                        !memory_gap[31] && !clear;
   assign discard     = memory_gap_valid && !clear && !accept;
   assign gap_shifted = gap_u >> BIN_SHIFT;

   // Bin selection: large gaps all land in the last bin.
   always_comb begin
      bin_idx = gap_shifted[BIN_W-1:0];
      if (gap_shifted > 32'(NUM_BINS - 1)) begin
         bin_idx = BIN_W'(NUM_BINS - 1);
      end
   end

   // Saturating sum; the 41st bit catches overflow of the 40-bit accumulator.
   always_comb begin
      gap_sum_ext  = {1'b0, gap_sum_reg} + {9'd0, gap_u};
      gap_sum_next = gap_sum_reg;
      if (accept) begin
         gap_sum_next = gap_sum_ext[40] ? SUM_MAX : gap_sum_ext[39:0];
      end
   end

   assign sum_full_next = &gap_sum_next;
   assign cnt_full_next = (sample_count_reg == CNT_MAX) ||
                          (accept && (sample_count_reg == CNT_MAX - CNT_ONE));
   assign sat_next      = (|bin_full_next) || cnt_full_next || sum_full_next;

   generate
      for (genvar gi = 0; gi < NUM_BINS; gi++) begin : gen_bin
         logic hit;
         assign hit = accept && (bin_idx == BIN_W'(gi));
         // Next-cycle all-ones detection so SATURATED is entered on the same edge.
         assign bin_full_next[gi] = (bin_reg[gi] == CNT_MAX) ||
                                    (hit && (bin_reg[gi] == CNT_MAX - CNT_ONE));

         // Per-bin saturating counter.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               bin_reg[gi] <= '0;
            end else if (clear) begin
               bin_reg[gi] <= '0;
            end else if (hit && (bin_reg[gi] != CNT_MAX)) begin
               bin_reg[gi] <= bin_reg[gi] + CNT_ONE;
            end
         end
      end
   endgenerate

   // Control FSM: IDLE/COLLECT follow enable; SATURATED is left only via clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else if (clear) begin
         state_reg <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (enable) state_reg <= COLLECT;
            end
            COLLECT: begin
               if (!enable)       state_reg <= IDLE;
               else if (sat_next) state_reg <= SATURATED;
            end
            SATURATED: begin
               state_reg <= SATURATED;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Running count, sum, min and max of accepted samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_count_reg <= '0;
         gap_sum_reg      <= '0;
         gap_min_reg      <= MIN_INIT;
         gap_max_reg      <= '0;
      end else if (clear) begin
         sample_count_reg <= '0;
         gap_sum_reg      <= '0;
         gap_min_reg      <= MIN_INIT;
         gap_max_reg      <= '0;
      end else if (accept) begin
         if (sample_count_reg != CNT_MAX) begin
            sample_count_reg <= sample_count_reg + CNT_ONE;
         end
         gap_sum_reg <= gap_sum_next;
         if (gap_u < gap_min_reg) gap_min_reg <= gap_u;
         if (gap_u > gap_max_reg) gap_max_reg <= gap_u;
      end
   end

   // Count of valid samples that were rejected, saturating at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         discard_count_reg <= '0;
      end else if (clear) begin
         discard_count_reg <= '0;
      end else if (discard && (discard_count_reg != 8'hFF)) begin
         discard_count_reg <= discard_count_reg + 8'd1;
      end
   end

   // Registered bin read; sees the pre-update / pre-clear bin value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= rd_req;
         if (rd_req) begin
            rd_data_reg <= (32'(rd_bin) < NUM_BINS) ? bin_reg[rd_bin] : '0;
         end
      end
   end

   assign state         = state_reg;
   assign rd_valid      = rd_valid_reg;
   assign rd_data       = rd_data_reg;
   assign sample_count  = sample_count_reg;
   assign gap_min       = gap_min_reg;
   assign gap_max       = gap_max_reg;
   assign gap_sum       = gap_sum_reg;
   assign discard_count = discard_count_reg;

endmodule

// File: tb/tb_memory_gap_stats.sv
// Directed bench for memory_gap_stats (CNT_W=4 so saturation is reachable).
// Bin reads are checked by a scoreboard monitor; statistics are checked inline.
module tb_memory_gap_stats;

   localparam int NB = 8;
   localparam int BS = 2;
   localparam int CW = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] memory_gap;
   logic               memory_gap_valid;
   logic               enable;
   logic               clear;
   logic               rd_req;
   logic [2:0]         rd_bin;
   logic               rd_valid;
   logic [CW-1:0]      rd_data;
   logic [CW-1:0]      sample_count;
   logic [31:0]        gap_min;
   logic [31:0]        gap_max;
   logic [39:0]        gap_sum;
   logic [7:0]         discard_count;
   logic [1:0]         state;

   typedef struct {
      string         name;
      logic [CW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   memory_gap_stats #(.NUM_BINS(NB), .BIN_SHIFT(BS), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .memory_gap       (memory_gap),
      .memory_gap_valid (memory_gap_valid),
      .enable           (enable),
      .clear            (clear),
      .rd_req           (rd_req),
      .rd_bin           (rd_bin),
      .rd_valid         (rd_valid),
      .rd_data          (rd_data),
      .sample_count     (sample_count),
      .gap_min          (gap_min),
      .gap_max          (gap_max),
      .gap_sum          (gap_sum),
      .discard_count    (discard_count),
      .state            (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_gap(input int g);
      memory_gap       = g;
      memory_gap_valid = 1'b1;
      tick();
      memory_gap_valid = 1'b0;
   endtask

   task automatic push_rd(input int b, input logic [CW-1:0] e, input string n);
      exp_t x;
      x.name = n;
      x.data = e;
      rd_req = 1'b1;
      rd_bin = 3'(b);
      exp_q.push_back(x);
   endtask

   task automatic rd(input int b, input logic [CW-1:0] e, input string n);
      push_rd(b, e, n);
      tick();
      rd_req = 1'b0;
   endtask

   task automatic check_stats(input string tag, input int cnt, input logic [31:0] mn,
                              input logic [31:0] mx, input logic [39:0] sm, input int dc);
      check({tag, "_count"},   64'(sample_count),  64'(cnt));
      check({tag, "_min"},     64'(gap_min),       64'(mn));
      check({tag, "_max"},     64'(gap_max),       64'(mx));
      check({tag, "_sum"},     64'(gap_sum),       64'(sm));
      check({tag, "_discard"}, 64'(discard_count), 64'(dc));
   endtask

   // Scoreboard monitor: every rd_valid pulse must match the oldest expected read.
   always @(negedge clk) begin
      exp_t e;
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid: got rd_data=%0d expected no response", rd_data);
         end else begin
            e = exp_q.pop_front();
            check(e.name, 64'(rd_data), 64'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      memory_gap       = 0;
      memory_gap_valid = 1'b0;
      enable           = 1'b0;
      clear            = 1'b0;
      rd_req           = 1'b0;
      rd_bin           = 3'd0;
      tick();
      tick();
      check("rst_state",    64'(state),    64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data",  64'(rd_data),  64'd0);
      check_stats("rst", 0, 32'h7FFF_FFFF, 0, 0, 0);
      rst = 1'b0;

      // Valid sample while IDLE is discarded; clear zeroes the discard count.
      send_gap(5);
      check("idle_discard", 64'(discard_count), 64'd1);
      check("idle_count",   64'(sample_count),  64'd0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_discard", 64'(discard_count), 64'd0);

      enable = 1'b1;
      tick();
      check("enter_collect", 64'(state), 64'd1);

      // Basic histogram: gaps 0,3 -> bin0, 4 -> bin1, 100 -> clamped bin7.
      send_gap(0);
      send_gap(3);
      send_gap(4);
      send_gap(100);
      check_stats("hist", 4, 0, 100, 107, 0);
      push_rd(0, 4'd2, "rd_bin0"); tick();
      push_rd(1, 4'd1, "rd_bin1"); tick();
      push_rd(7, 4'd1, "rd_bin7"); tick();
      push_rd(2, 4'd0, "rd_bin2"); tick();
      rd_req = 1'b0;

      // Negative gap only bumps the discard count.
      send_gap(-1);
      check_stats("neg", 4, 0, 100, 107, 1);

      // Read coincident with an update of the same bin returns the old value.
      send_gap(5);
      memory_gap       = 6;
      memory_gap_valid = 1'b1;
      push_rd(1, 4'd2, "rd_coincident");
      tick();
      memory_gap_valid = 1'b0;
      rd_req           = 1'b0;
      rd(1, 4'd3, "rd_reread");
      check("upd_count", 64'(sample_count), 64'd6);
      check("upd_sum",   64'(gap_sum),      64'd118);

      // Clear with a coincident sample and read: clear wins, read sees pre-clear.
      clear            = 1'b1;
      memory_gap       = 5;
      memory_gap_valid = 1'b1;
      push_rd(1, 4'd3, "rd_preclear");
      tick();
      clear            = 1'b0;
      memory_gap_valid = 1'b0;
      rd_req           = 1'b0;
      check_stats("clr", 0, 32'h7FFF_FFFF, 0, 0, 0);
      check("clr_state", 64'(state), 64'd0);
      rd(1, 4'd0, "rd_postclear");
      check("clr_recollect", 64'(state), 64'd1);

      // Clamping to the last bin, including the largest positive gap.
      send_gap(31);
      send_gap(32);
      send_gap(32'h7FFF_FFFF);
      rd(7, 4'd3, "rd_clamp_bin7");
      check_stats("clamp", 3, 31, 32'h7FFF_FFFF, 40'h00_8000_003E, 0);

      // Saturation with 4-bit counters.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check("sat_pre_state", 64'(state), 64'd1);
      memory_gap       = 1;
      memory_gap_valid = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      memory_gap_valid = 1'b0;
      check("sat_state", 64'(state),        64'd2);
      check("sat_count", 64'(sample_count), 64'd15);
      send_gap(1);
      check("sat_discard", 64'(discard_count), 64'd1);
      rd(0, 4'd15, "rd_sat_bin0");
      enable = 1'b0;
      tick();
      check("sat_hold_state", 64'(state),        64'd2);
      check("sat_hold_count", 64'(sample_count), 64'd15);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("sat_exit_state", 64'(state), 64'd0);

      // Reset in the middle of a read cancels rd_valid and drops the sample.
      enable = 1'b1;
      tick();
      send_gap(2);
      check("prerst_count", 64'(sample_count), 64'd1);
      memory_gap       = 2;
      memory_gap_valid = 1'b1;
      rd_req           = 1'b1;
      rd_bin           = 3'd0;
      tick();
      rst = 1'b1;
      #1;
      check("rst_cancel_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_cancel_rd_data",  64'(rd_data),  64'd0);
      check("rst_cancel_state",    64'(state),    64'd0);
      check_stats("rstmid", 0, 32'h7FFF_FFFF, 0, 0, 0);
      memory_gap_valid = 1'b0;
      rd_req           = 1'b0;
      tick();
      rst = 1'b0;

      // First sample after reset arrives while still IDLE: discarded.
      send_gap(9);
      check("postrst_state",   64'(state),         64'd1);
      check("postrst_count",   64'(sample_count),  64'd0);
      check("postrst_discard", 64'(discard_count), 64'd1);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_drain: got %0d pending reads expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
